// File: rtl/step_counter_pkg.sv
// ---------------------------------------------------------------------------
// step_counter_pkg
// Shared definitions for the step_counter block: default geometry, the
// range-limit constants used by the flag decode and the saturation clamp,
// and the count-direction encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package step_counter_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STEP_W = 4;

    // Limits are held at the widest supported counter and sliced down to
    // WIDTH by the user, so one constant serves every instance (WIDTH <= 64).
    localparam int               MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [MAX_WIDTH-1:0] CNT_MIN = '0;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/addsub_ripple.sv
// ---------------------------------------------------------------------------
// addsub_ripple
// Ripple-carry adder/subtractor built from a chain of full-adder cells.
// Subtraction is a + ~b + 1: b is inverted bit-wise by i_sub and i_sub is
// also the carry into bit 0.
// Ports:
//   i_a    [WIDTH-1:0]  first operand
//   i_b    [WIDTH-1:0]  second operand
//   i_sub               1 = a - b, 0 = a + b
//   o_sum  [WIDTH-1:0]  result modulo 2^WIDTH
//   o_cb                carry out (add) or borrow out (subtract)
// ---------------------------------------------------------------------------
module addsub_ripple #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cb
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_bx;

    assign w_c[0] = i_sub;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        assign w_bx[gi]   = i_b[gi] ^ i_sub;
        assign o_sum[gi]  = i_a[gi] ^ w_bx[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & w_bx[gi]) | (w_c[gi] & (i_a[gi] ^ w_bx[gi]));
    end

    // In two's-complement subtraction a carry out means "no borrow", so the
    // raw carry is inverted when subtracting.
    assign o_cb = w_c[WIDTH] ^ i_sub;

endmodule

// File: rtl/step_counter.sv
// ---------------------------------------------------------------------------
// step_counter
// Registered up/down counter with programmable step, synchronous load and a
// one-cycle carry pulse whenever an update crosses the range boundary.
// Build option: define COUNTER_SAT_EN to clamp at the limits instead of
// wrapping (carry still pulses on every clamping update).
// Ports:
//   clk                     rising-edge clock
//   rst_n                   asynchronous active-low reset
//   en                      count enable
//   load                    synchronous load strobe (wins over en)
//   load_val [WIDTH-1:0]    value taken on load
//   dir                     1 = count up, 0 = count down
//   step     [STEP_W-1:0]   unsigned increment, zero-extended
//   count    [WIDTH-1:0]    registered counter value
//   carry                   registered overflow/borrow pulse
//   at_max                  count is all ones
//   at_min                  count is zero
// ---------------------------------------------------------------------------
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic              carry,
    output logic              at_max,
    output logic              at_min
);

    localparam logic [WIDTH-1:0] L_MAX = CNT_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] L_MIN = CNT_MIN[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic             r_carry;

    dir_e             w_dir;
    logic [WIDTH-1:0] w_step_ext;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_upd;

    assign w_dir      = dir_e'(dir);
    assign w_step_ext = WIDTH'(step);

    addsub_ripple #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a   (r_count),
        .i_b   (w_step_ext),
        .i_sub (w_dir == DIR_DOWN),
        .o_sum (w_sum),
        .o_cb  (w_ovf)
    );

`ifdef COUNTER_SAT_EN
    // Clamp to the limit in the direction of travel. A zero step never
    // overflows, so a counter parked at a limit stays quiet until stepped.
    assign w_upd = w_ovf ? ((w_dir == DIR_UP) ? L_MAX : L_MIN) : w_sum;
`else
    assign w_upd = w_sum;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= L_MIN;
            r_carry <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_carry <= 1'b0;
        end else if (en) begin
            r_count <= w_upd;
            r_carry <= w_ovf;
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign count  = r_count;
    assign carry  = r_carry;
    assign at_max = (r_count == L_MAX);
    assign at_min = (r_count == L_MIN);

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised registered up/down counter with programmable step, synchronous load and wrap/overflow signalling. Next-generation replacement for the fixed 4-bit combinational incrementer. Used wherever the design needs a stepped address, event or loop count. Arithmetic goes through a ripple add/subtract datapath built from the team's full-adder cells.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- STEP_W, 4, step input width in bits (1..WIDTH)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value taken on load
- dir  input  1  1 = count up, 0 = count down
- step  input  STEP_W  unsigned increment, zero-extended to WIDTH
- count  output  WIDTH  registered counter value
- carry  output  1  registered one-cycle pulse: the previous update crossed the range boundary
- at_max  output  1  count == 2^WIDTH−1 (combinational decode of count)
- at_min  output  1  count == 0 (combinational decode of count)

## Operation
- Reset (rst_n low, any time, asynchronous): count=0, carry=0; hence at_min=1, at_max=0. Takes effect immediately, mid-operation included; the first update is on the first clk edge after release.
- Priority at each edge: load > en > hold.
- load=1: count←load_val, carry←0. en, dir and step are ignored.
- en=1, load=0, dir=1: sum = count + step, computed WIDTH+1 bits wide.
- en=1, load=0, dir=0: diff = count − step, computed WIDTH+1 bits wide; borrow = MSB.
- Default (wrap) mode: count←sum/diff mod 2^WIDTH; carry←1 if the operation overflowed (up) or borrowed (down), else 0.
- en=0, load=0: count holds, carry←0.
- step=0 with en=1: count holds, carry←0. Not an error.
- dir may change on any cycle. Each edge uses the dir sampled at that edge.
- No state machine. The only state is count and carry.

## Timing
- count, carry: registered. Single-cycle latency from load/en/dir/step/load_val sampled at edge N to the output valid after edge N.
- carry is high for exactly one cycle per overflow event. Back-to-back overflows give carry high on consecutive cycles.
- at_max/at_min follow count combinationally in the same cycle. No added latency.
- All inputs are synchronous to clk. Setup is measured against the rising edge.

## Configuration
- COUNTER_SAT_EN defined: saturating mode.
  - Up overflow clamps count to 2^WIDTH−1.
  - Down borrow clamps count to 0.
  - carry pulses on the clamping cycle, including when the counter is already at the limit and a non-zero step is applied.
- COUNTER_SAT_EN undefined: wrap mode as in Operation.
- load behaviour is identical in both modes.

## Structure
- Package step_counter_pkg holds:
  - default WIDTH/STEP_W constants
  - localparam helpers for CNT_MAX (all ones) and CNT_MIN (zero)
  - a dir_e typedef (DIR_DOWN=0, DIR_UP=1)
- One sub-module, addsub_ripple, parametrised by WIDTH:
  - a, b and sub inputs; WIDTH result plus carry/borrow out
  - chain of full-adder cells with b XOR sub and carry-in = sub
- The top level adds only the register, priority mux, saturation clamp and flag decode.

## Test plan
- Reset mid-count: WIDTH=4, counting up at count=9, pull rst_n low between edges → count=0 and carry=0 immediately; at_min=1.
- Wrap up: WIDTH=4, load 14, dir=1, step=3, en=1 → next count=1, carry=1 for one cycle, then count=4 with carry=0.
- Wrap down: WIDTH=4, load 2, dir=0, step=5 → count=13, carry=1. Next edge → count=8, carry=0.
- Priority: load=1, en=1, load_val=7, step=2 → count=7, carry=0. Then en=1, step=0 → count stays 7.
- Saturation (COUNTER_SAT_EN): WIDTH=4, load 13, dir=1, step=4 → count=15, carry=1, at_max=1. Repeat → count=15, carry=1. dir=0, step=1 → count=14, carry=0.
- Exhaustive sweep: WIDTH=4, STEP_W=2, all count/step/dir combinations, compared against a reference model in both macro builds.
